pe_decimate_stream: RTL and testbench

PE_DECIMATE_STREAM -- requirements
Module: pe_decimate_stream

---
 rtl/pe_decimate_stream_pkg.sv | 10 +
 rtl/pe_decimate_stream_if.sv | 14 +
 rtl/pe_sync_fifo.sv | 71 +++++++
 rtl/pe_decimate_stream.sv | 129 ++++++++++++
 tb/tb_pe_decimate_stream.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/pe_decimate_stream_pkg.sv
// Shared FSM encoding and default widths for the phase-error decimator.
package pe_decimate_stream_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ACC_WIDTH  = 48;

  typedef enum logic {
    UNPRIMED = 1'b0,
    RUN      = 1'b1
  } state_t;
endpackage

// File: rtl/pe_decimate_stream_if.sv
// AXI-Stream style bundle used for both the phase-error input and the averaged output.
interface pe_decimate_stream_if
  import pe_decimate_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/pe_sync_fifo.sv
// Single-clock FIFO whose head word and empty flag come straight from flops.
module pe_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_drop
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_empty;
  logic [WIDTH-1:0] r_data;

  logic             w_do_pop;
  logic             w_do_push;
  logic [AW-1:0]    w_rd_next;
  logic [AW:0]      w_count_next;
  logic [WIDTH-1:0] w_head_next;

  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
  assign o_full       = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop     = i_pop && !r_empty;
  assign w_do_push    = i_push && (!o_full || w_do_pop);
  assign o_drop       = i_push && !w_do_push;
  assign w_rd_next    = r_rd_ptr + AW'(w_do_pop);
  assign w_count_next = r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
  assign o_data       = r_data;
  assign o_empty      = r_empty;

  // Next head: bypass the incoming word when it becomes the only entry.
  always_comb begin
    w_head_next = r_data;
    if (w_do_push && (r_count == (AW+1)'(w_do_pop)))
      w_head_next = i_data;
    else if (w_count_next != '0)
      w_head_next = r_mem[w_rd_next];
  end

  always_ff @(posedge clk) begin
    if (w_do_push)
      r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_data   <= '0;
    end else begin
      if (w_do_push)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      r_rd_ptr <= w_rd_next;
      r_count  <= w_count_next;
      r_empty  <= (w_count_next == '0);
      r_data   <= w_head_next;
    end
  end
endmodule

// File: rtl/pe_decimate_stream.sv
// Unwraps phase-error samples, boxcar-averages 2^LOG2_AVG of them, and streams
// the averages out through a buffer with framing and drop accounting.
module pe_decimate_stream
  import pe_decimate_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int LOG2_AVG   = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int FRAME_LEN  = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  pe_decimate_stream_if.slave  S_AXIS_PE,
  pe_decimate_stream_if.master M_AXIS_AVG,
  output logic                 overflow,
  output logic [15:0]          drop_count
);
  localparam int SUM_W = ACC_WIDTH + LOG2_AVG;
  localparam int FW    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_LEN - 1);

  state_t                  r_state;
  logic [DATA_WIDTH-1:0]   r_prev;
  logic [ACC_WIDTH-1:0]    r_u;
  logic signed [SUM_W-1:0] r_sum;
  logic [LOG2_AVG-1:0]     r_cnt;
  logic                    r_push;
  logic [DATA_WIDTH-1:0]   r_push_data;
  logic                    r_overflow;
  logic [15:0]             r_drop_count;
  logic [FW-1:0]           r_frame;

  logic                    w_accept;
  logic                    w_block_done;
  logic [DATA_WIDTH-1:0]   w_delta;
  logic [ACC_WIDTH-1:0]    w_u_next;
  logic signed [SUM_W-1:0] w_sum_next;
  logic [DATA_WIDTH-1:0]   w_avg;
  logic                    w_pop;
  logic                    w_empty;
  logic                    w_full;
  logic                    w_drop;
  logic [DATA_WIDTH-1:0]   w_fifo_data;
  logic                    w_unused_tlast;
  logic                    w_unused_full;

  assign w_accept     = en && S_AXIS_PE.tvalid;
  assign w_block_done = w_accept && (r_cnt == '1);
  assign w_delta      = S_AXIS_PE.tdata - r_prev;

  // The first sample seeds the unwrapped phase; later ones add the wrapped difference.
  always_comb begin
    if (r_state == UNPRIMED)
      w_u_next = {{(ACC_WIDTH-DATA_WIDTH){S_AXIS_PE.tdata[DATA_WIDTH-1]}}, S_AXIS_PE.tdata};
    else
      w_u_next = r_u + {{(ACC_WIDTH-DATA_WIDTH){w_delta[DATA_WIDTH-1]}}, w_delta};
  end

  assign w_sum_next = r_sum + {{LOG2_AVG{w_u_next[ACC_WIDTH-1]}}, w_u_next};
  assign w_avg      = DATA_WIDTH'(w_sum_next >>> LOG2_AVG);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= UNPRIMED;
      r_prev      <= '0;
      r_u         <= '0;
      r_sum       <= '0;
      r_cnt       <= '0;
      r_push      <= 1'b0;
      r_push_data <= '0;
    end else begin
      r_push <= w_block_done;
      if (w_block_done)
        r_push_data <= w_avg;
      if (w_accept) begin
        r_state <= RUN;
        r_prev  <= S_AXIS_PE.tdata;
        r_u     <= w_u_next;
        r_cnt   <= r_cnt + LOG2_AVG'(1);
        r_sum   <= w_block_done ? '0 : w_sum_next;
      end
    end
  end

  pe_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_push),
    .i_data  (r_push_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_drop  (w_drop)
  );

  assign w_pop = !w_empty && M_AXIS_AVG.tready;

  // Frame position advances per transfer; drop statistics saturate rather than wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame      <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      if (w_pop)
        r_frame <= (r_frame == FRAME_LAST) ? '0 : r_frame + FW'(1);
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != 16'hFFFF)
          r_drop_count <= r_drop_count + 16'd1;
      end
    end
  end

  assign M_AXIS_AVG.tdata  = w_fifo_data;
  assign M_AXIS_AVG.tvalid = !w_empty;
  assign M_AXIS_AVG.tlast  = !w_empty && (r_frame == FRAME_LAST);
  assign S_AXIS_PE.tready  = 1'b1;
  assign overflow          = r_overflow;
  assign drop_count        = r_drop_count;
  assign w_unused_tlast    = S_AXIS_PE.tlast;
  assign w_unused_full     = w_full;
endmodule

// File: tb/tb_pe_decimate_stream.sv
// Directed bench for pe_decimate_stream: one task per scenario, 4-word frames.
module tb_pe_decimate_stream;
  localparam int DW = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        overflow;
  logic [15:0] drop_count;
  int          nPass = 0;
  int          nTotal = 0;

  logic [DW-1:0] capData[$];
  logic          capLast[$];

  pe_decimate_stream_if #(.DATA_WIDTH(DW)) s_if ();
  pe_decimate_stream_if #(.DATA_WIDTH(DW)) m_if ();

  pe_decimate_stream #(
    .DATA_WIDTH (DW),
    .ACC_WIDTH  (48),
    .LOG2_AVG   (4),
    .FIFO_DEPTH (16),
    .FRAME_LEN  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .S_AXIS_PE  (s_if),
    .M_AXIS_AVG (m_if),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #4 clk = ~clk;

  // Every accepted output word is recorded with its tlast flag.
  always @(posedge clk) begin
    if (!rst && m_if.tvalid && m_if.tready) begin
      capData.push_back(m_if.tdata);
      capLast.push_back(m_if.tlast);
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyReset();
    rst         = 1'b1;
    en          = 1'b1;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b0;
    idle(3);
    rst = 1'b0;
    capData.delete();
    capLast.delete();
  endtask

  task automatic sendSample(input logic [DW-1:0] x);
    s_if.tdata  = x;
    s_if.tvalid = 1'b1;
    idle(1);
    s_if.tvalid = 1'b0;
  endtask

  task automatic sendBlock(input logic [DW-1:0] x);
    for (int i = 0; i < 16; i++) sendSample(x);
  endtask

  function automatic logic [DW-1:0] capAt(input int idx);
    return (idx < capData.size()) ? capData[idx] : 32'hDEADBEEF;
  endfunction

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; m_if.tready = 1'b1;
    idle(2);
    nTotal++; if (m_if.tvalid !== 1'b0) $display("[TB] FAIL reset_tvalid: got %0h expected 0", m_if.tvalid); else nPass++;
    nTotal++; if (m_if.tlast !== 1'b0) $display("[TB] FAIL reset_tlast: got %0h expected 0", m_if.tlast); else nPass++;
    nTotal++; if (m_if.tdata !== '0) $display("[TB] FAIL reset_tdata: got %0h expected 0", m_if.tdata); else nPass++;
    nTotal++; if (overflow !== 1'b0) $display("[TB] FAIL reset_overflow: got %0h expected 0", overflow); else nPass++;
    nTotal++; if (drop_count !== 16'd0) $display("[TB] FAIL reset_drop_count: got %0h expected 0", drop_count); else nPass++;
    rst = 1'b0;
  endtask

  task automatic test_constant();
    applyReset();
    m_if.tready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      sendSample(32'd1000);
      idle(7);
    end
    idle(4);
    nTotal++; if (capData.size() !== 2) $display("[TB] FAIL const_count: got %0d expected 2", capData.size()); else nPass++;
    nTotal++; if (capAt(0) !== 32'd1000) $display("[TB] FAIL const_word0: got %0d expected 1000", capAt(0)); else nPass++;
    nTotal++; if (capAt(1) !== 32'd1000) $display("[TB] FAIL const_word1: got %0d expected 1000", capAt(1)); else nPass++;
    nTotal++; if (overflow !== 1'b0) $display("[TB] FAIL const_overflow: got %0h expected 0", overflow); else nPass++;
  endtask

  task automatic test_latency();
    applyReset();
    for (int i = 0; i < 16; i++) sendSample(32'd7);
    nTotal++; if (m_if.tvalid !== 1'b0) $display("[TB] FAIL lat_n1_tvalid: got %0h expected 0", m_if.tvalid); else nPass++;
    idle(1);
    nTotal++; if (m_if.tvalid !== 1'b1) $display("[TB] FAIL lat_n2_tvalid: got %0h expected 1", m_if.tvalid); else nPass++;
    nTotal++; if (m_if.tdata !== 32'd7) $display("[TB] FAIL lat_n2_tdata: got %0h expected 7", m_if.tdata); else nPass++;
    idle(3);
    nTotal++; if ({m_if.tvalid, m_if.tdata} !== {1'b1, 32'd7}) $display("[TB] FAIL lat_hold: got %0h/%0h expected 1/7", m_if.tvalid, m_if.tdata); else nPass++;
    m_if.tready = 1'b1;
    idle(3);
    nTotal++; if (capData.size() !== 1) $display("[TB] FAIL lat_count: got %0d expected 1", capData.size()); else nPass++;
  endtask

  task automatic test_wrap();
    applyReset();
    m_if.tready = 1'b1;
    for (int k = 0; k < 32; k++) sendSample(32'hFFFFFFF1 + DW'(k));
    idle(4);
    nTotal++; if (capData.size() !== 2) $display("[TB] FAIL wrap_count: got %0d expected 2", capData.size()); else nPass++;
    nTotal++; if (capAt(0) !== 32'hFFFFFFF8) $display("[TB] FAIL wrap_neg_floor: got %0h expected fffffff8", capAt(0)); else nPass++;
    nTotal++; if (capAt(1) !== 32'd8) $display("[TB] FAIL wrap_across_zero: got %0h expected 8", capAt(1)); else nPass++;
  endtask

  task automatic test_overflow();
    applyReset();
    for (int b = 0; b < 20; b++) sendBlock(DW'(100 * b + 3));
    idle(3);
    nTotal++; if (overflow !== 1'b1) $display("[TB] FAIL ovf_flag: got %0h expected 1", overflow); else nPass++;
    nTotal++; if (drop_count !== 16'd4) $display("[TB] FAIL ovf_drop_count: got %0d expected 4", drop_count); else nPass++;
    m_if.tready = 1'b1;
    idle(20);
    nTotal++; if (capData.size() !== 16) $display("[TB] FAIL ovf_drain_count: got %0d expected 16", capData.size()); else nPass++;
    for (int i = 0; i < 16; i++) begin
      nTotal++; if (capAt(i) !== DW'(100 * i + 3)) $display("[TB] FAIL ovf_word%0d: got %0d expected %0d", i, capAt(i), 100 * i + 3); else nPass++;
    end
    nTotal++; if (m_if.tvalid !== 1'b0) $display("[TB] FAIL ovf_empty: got %0h expected 0", m_if.tvalid); else nPass++;
  endtask

  task automatic test_full_push_pop();
    applyReset();
    for (int b = 0; b < 16; b++) sendBlock(DW'(10 * b + 1));
    idle(2);
    sendBlock(32'd777);
    m_if.tready = 1'b1;
    idle(1);
    m_if.tready = 1'b0;
    idle(2);
    nTotal++; if (drop_count !== 16'd0) $display("[TB] FAIL fpp_drop_count: got %0d expected 0", drop_count); else nPass++;
    nTotal++; if (overflow !== 1'b0) $display("[TB] FAIL fpp_overflow: got %0h expected 0", overflow); else nPass++;
    m_if.tready = 1'b1;
    idle(20);
    nTotal++; if (capData.size() !== 17) $display("[TB] FAIL fpp_count: got %0d expected 17", capData.size()); else nPass++;
    nTotal++; if (capAt(1) !== 32'd11) $display("[TB] FAIL fpp_second: got %0d expected 11", capAt(1)); else nPass++;
    nTotal++; if (capAt(16) !== 32'd777) $display("[TB] FAIL fpp_last: got %0d expected 777", capAt(16)); else nPass++;
  endtask

  task automatic test_frame();
    logic [7:0] readyPat;
    readyPat = 8'b0110_1101;
    applyReset();
    for (int b = 0; b < 12; b++) sendBlock(DW'(5 * b));
    idle(3);
    for (int i = 0; i < 40; i++) begin
      m_if.tready = readyPat[i % 8];
      idle(1);
    end
    m_if.tready = 1'b0;
    nTotal++; if (capData.size() !== 12) $display("[TB] FAIL frame_count: got %0d expected 12", capData.size()); else nPass++;
    for (int i = 0; i < 12; i++) begin
      nTotal++;
      if (i < capLast.size() && capLast[i] === ((i % 4) == 3) && capAt(i) === DW'(5 * i)) nPass++;
      else $display("[TB] FAIL frame_xfer%0d: got last=%0h data=%0d expected last=%0h data=%0d", i + 1, (i < capLast.size()) ? capLast[i] : 1'b0, capAt(i), (i % 4) == 3, 5 * i);
    end
  endtask

  task automatic test_reset_mid();
    applyReset();
    sendBlock(32'd300);
    for (int i = 0; i < 9; i++) sendSample(32'd900);
    idle(2);
    nTotal++; if (m_if.tvalid !== 1'b1) $display("[TB] FAIL rmid_pre_tvalid: got %0h expected 1", m_if.tvalid); else nPass++;
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    nTotal++; if (m_if.tvalid !== 1'b0) $display("[TB] FAIL rmid_post_tvalid: got %0h expected 0", m_if.tvalid); else nPass++;
    m_if.tready = 1'b1;
    sendBlock(32'd500);
    idle(4);
    nTotal++; if (capData.size() !== 1) $display("[TB] FAIL rmid_count: got %0d expected 1", capData.size()); else nPass++;
    nTotal++; if (capAt(0) !== 32'd500) $display("[TB] FAIL rmid_word: got %0d expected 500", capAt(0)); else nPass++;
  endtask

  task automatic test_enable();
    applyReset();
    for (int i = 0; i < 8; i++) sendSample(32'd40);
    en = 1'b0;
    for (int i = 0; i < 5; i++) sendSample(32'd9999);
    en = 1'b1;
    for (int i = 0; i < 8; i++) sendSample(32'd40);
    idle(2);
    en = 1'b0;
    m_if.tready = 1'b1;
    for (int i = 0; i < 3; i++) sendSample(32'd1234);
    idle(3);
    en = 1'b1;
    nTotal++; if (capData.size() !== 1) $display("[TB] FAIL en_count: got %0d expected 1", capData.size()); else nPass++;
    nTotal++; if (capAt(0) !== 32'd40) $display("[TB] FAIL en_word: got %0d expected 40", capAt(0)); else nPass++;
  endtask

  initial begin
    test_reset();
    test_constant();
    test_latency();
    test_wrap();
    test_overflow();
    test_full_push_pop();
    test_frame();
    test_reset_mid();
    test_enable();
    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end
endmodule
